// File: rtl/decode_pkg.sv
// Shared encodings for the ID stage: opcode/funct values, PC-source codes, NOP encoding
// and the exception vector that fetch hardwires for the exception PC-source code.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        PCSRC_BRANCH = 2'b00,
        PCSRC_REG    = 2'b01,
        PCSRC_INDEX  = 2'b10,
        PCSRC_EXC    = 2'b11
    } pcsrc_e;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] EXC_VECTOR = 32'h0000_0040;

    function automatic logic rtype_funct_legal(input logic [5:0] funct);
        case (funct)
            FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_SLL, FN_JR: rtype_funct_legal = 1'b1;
            default:                                              rtype_funct_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port, r0 reads zero.
// Define DECODE_WB_BYPASS_EN to forward same-cycle writeback data to the read ports.
module decode_regfile
    import decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  ra_idx,
    input  logic [4:0]  rb_idx,
    output logic [31:0] ra_data,
    output logic [31:0] rb_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_idx,
    input  logic [31:0] wr_data
);

    logic [31:0] regs_r [0:31];

    // register storage; r0 is never written so it stays zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_r[i] <= 32'h0000_0000;
            end
        end else if (wr_en && (wr_idx != 5'd0)) begin
            regs_r[wr_idx] <= wr_data;
        end else begin
            regs_r[wr_idx] <= regs_r[wr_idx];
        end
    end

    // read ports, with optional same-cycle writeback bypass
    always_comb begin
        ra_data = 32'h0000_0000;
        rb_data = 32'h0000_0000;
        if (ra_idx == 5'd0) begin
            ra_data = 32'h0000_0000;
`ifdef DECODE_WB_BYPASS_EN
        end else if (wr_en && (wr_idx == ra_idx)) begin
            ra_data = wr_data;
`endif
        end else begin
            ra_data = regs_r[ra_idx];
        end
        if (rb_idx == 5'd0) begin
            rb_data = 32'h0000_0000;
`ifdef DECODE_WB_BYPASS_EN
        end else if (wr_en && (wr_idx == rb_idx)) begin
            rb_data = wr_data;
`endif
        end else begin
            rb_data = regs_r[rb_idx];
        end
    end

endmodule

// File: rtl/decode.sv
// ID stage of the word-addressed MIPS-subset pipeline: decode, register file, PC redirect,
// ID/EX register and illegal-instruction exception. Optional macro: DECODE_WB_BYPASS_EN.
module decode
    import decode_pkg::*;
#(
    parameter logic [4:0] LINK_REG = 5'd31
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_id_instruc,
    input  logic [31:0] if_id_nextpc,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    input  logic        wb_id_regwrite,
    input  logic [4:0]  wb_id_writereg,
    input  logic [31:0] wb_id_writedata,
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [4:0]  id_ex_regdest,
    output logic        id_ex_regwrite,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic [5:0]  id_ex_opcode,
    output logic [5:0]  id_ex_funct,
    output logic [31:0] id_ex_nextpc,
    output logic [31:0] id_epc
);

    logic [5:0]  op_s, funct_s;
    logic [4:0]  rs_s, rt_s, rd_s;
    logic [15:0] imm_s;
    logic [31:0] rega_s, regb_s, sext_s, imedext_s;
    logic [4:0]  regdest_s;
    logic        legal_s, regwrite_s, memread_s, memwrite_s, exception_s, squash_r;

    assign op_s    = if_id_instruc[31:26];
    assign rs_s    = if_id_instruc[25:21];
    assign rt_s    = if_id_instruc[20:16];
    assign rd_s    = if_id_instruc[15:11];
    assign funct_s = if_id_instruc[5:0];
    assign imm_s   = if_id_instruc[15:0];
    assign sext_s  = {{16{imm_s[15]}}, imm_s};

    decode_regfile u_regfile (
        .clock   (clock),
        .reset   (reset),
        .ra_idx  (rs_s),
        .rb_idx  (rt_s),
        .ra_data (rega_s),
        .rb_data (regb_s),
        .wr_en   (wb_id_regwrite),
        .wr_idx  (wb_id_writereg),
        .wr_data (wb_id_writedata)
    );

    assign id_if_pcimd2ext = if_id_nextpc + sext_s;
    assign id_if_rega      = rega_s;
    assign id_if_pcindex   = {if_id_nextpc[31:26], if_id_instruc[25:0]};

    // instruction decode: legality, immediate form, destination and control bits
    always_comb begin
        legal_s    = 1'b0;
        regwrite_s = 1'b0;
        memread_s  = 1'b0;
        memwrite_s = 1'b0;
        regdest_s  = rt_s;
        imedext_s  = sext_s;
        case (op_s)
            OP_RTYPE: begin
                legal_s    = rtype_funct_legal(funct_s);
                regwrite_s = (funct_s != FN_JR);
                regdest_s  = rd_s;
            end
            OP_ADDI: begin legal_s = 1'b1; regwrite_s = 1'b1; end
            OP_ANDI, OP_ORI: begin
                legal_s    = 1'b1;
                regwrite_s = 1'b1;
                imedext_s  = {16'h0000, imm_s};
            end
            OP_LUI: begin
                legal_s    = 1'b1;
                regwrite_s = 1'b1;
                imedext_s  = {imm_s, 16'h0000};
            end
            OP_LW:  begin legal_s = 1'b1; regwrite_s = 1'b1; memread_s = 1'b1; end
            OP_SW:  begin legal_s = 1'b1; memwrite_s = 1'b1; end
            OP_BEQ, OP_BNE, OP_J: begin legal_s = 1'b1; end
            OP_JAL: begin legal_s = 1'b1; regwrite_s = 1'b1; regdest_s = LINK_REG; end
            default: begin legal_s = 1'b0; end
        endcase
    end

    assign exception_s = !squash_r && !legal_s;

    // PC redirect request to fetch; a squashed delay slot never redirects
    always_comb begin
        id_if_selpcsource = 1'b0;
        id_if_selpctype   = PCSRC_BRANCH;
        if (squash_r) begin
            id_if_selpcsource = 1'b0;
        end else if (!legal_s) begin
            id_if_selpcsource = 1'b1;
            id_if_selpctype   = PCSRC_EXC;
        end else begin
            case (op_s)
                OP_BEQ: id_if_selpcsource = (rega_s == regb_s);
                OP_BNE: id_if_selpcsource = (rega_s != regb_s);
                OP_J, OP_JAL: begin
                    id_if_selpcsource = 1'b1;
                    id_if_selpctype   = PCSRC_INDEX;
                end
                OP_RTYPE: begin
                    if (funct_s == FN_JR) begin
                        id_if_selpcsource = 1'b1;
                        id_if_selpctype   = PCSRC_REG;
                    end else begin
                        id_if_selpcsource = 1'b0;
                    end
                end
                default: id_if_selpcsource = 1'b0;
            endcase
        end
    end

    // exception PC capture and one-cycle delay-slot squash flag
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            squash_r <= 1'b0;
            id_epc   <= 32'h0000_0000;
        end else if (exception_s) begin
            squash_r <= 1'b1;
            id_epc   <= if_id_nextpc - 32'd1;
        end else begin
            squash_r <= 1'b0;
            id_epc   <= id_epc;
        end
    end

    // ID/EX pipeline register; illegal or squashed instructions become an all-zero NOP
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            id_ex_rega     <= 32'h0000_0000;
            id_ex_regb     <= 32'h0000_0000;
            id_ex_imedext  <= 32'h0000_0000;
            id_ex_regdest  <= 5'd0;
            id_ex_regwrite <= 1'b0;
            id_ex_memread  <= 1'b0;
            id_ex_memwrite <= 1'b0;
            id_ex_opcode   <= 6'h00;
            id_ex_funct    <= 6'h00;
            id_ex_nextpc   <= 32'h0000_0000;
        end else if (squash_r || !legal_s) begin
            id_ex_rega     <= 32'h0000_0000;
            id_ex_regb     <= 32'h0000_0000;
            id_ex_imedext  <= 32'h0000_0000;
            id_ex_regdest  <= 5'd0;
            id_ex_regwrite <= 1'b0;
            id_ex_memread  <= 1'b0;
            id_ex_memwrite <= 1'b0;
            id_ex_opcode   <= NOP_INSTR[31:26];
            id_ex_funct    <= NOP_INSTR[5:0];
            id_ex_nextpc   <= 32'h0000_0000;
        end else begin
            id_ex_rega     <= rega_s;
            id_ex_regb     <= regb_s;
            id_ex_imedext  <= imedext_s;
            id_ex_regdest  <= regdest_s;
            id_ex_regwrite <= regwrite_s;
            id_ex_memread  <= memread_s;
            id_ex_memwrite <= memwrite_s;
            id_ex_opcode   <= op_s;
            id_ex_funct    <= funct_s;
            id_ex_nextpc   <= if_id_nextpc;
        end
    end

endmodule

// File: tb/tb_decode.sv
// Directed self-checking bench for the decode ID stage.
module tb_decode;

    logic        clock;
    logic        reset;
    logic [31:0] if_id_instruc;
    logic [31:0] if_id_nextpc;
    logic        id_if_selpcsource;
    logic [1:0]  id_if_selpctype;
    logic [31:0] id_if_pcimd2ext;
    logic [31:0] id_if_rega;
    logic [31:0] id_if_pcindex;
    logic        wb_id_regwrite;
    logic [4:0]  wb_id_writereg;
    logic [31:0] wb_id_writedata;
    logic [31:0] id_ex_rega, id_ex_regb, id_ex_imedext, id_ex_nextpc, id_epc;
    logic [4:0]  id_ex_regdest;
    logic        id_ex_regwrite, id_ex_memread, id_ex_memwrite;
    logic [5:0]  id_ex_opcode, id_ex_funct;

    int checks = 0;
    int errors = 0;

    decode dut (
        .clock             (clock),
        .reset             (reset),
        .if_id_instruc     (if_id_instruc),
        .if_id_nextpc      (if_id_nextpc),
        .id_if_selpcsource (id_if_selpcsource),
        .id_if_selpctype   (id_if_selpctype),
        .id_if_pcimd2ext   (id_if_pcimd2ext),
        .id_if_rega        (id_if_rega),
        .id_if_pcindex     (id_if_pcindex),
        .wb_id_regwrite    (wb_id_regwrite),
        .wb_id_writereg    (wb_id_writereg),
        .wb_id_writedata   (wb_id_writedata),
        .id_ex_rega        (id_ex_rega),
        .id_ex_regb        (id_ex_regb),
        .id_ex_imedext     (id_ex_imedext),
        .id_ex_regdest     (id_ex_regdest),
        .id_ex_regwrite    (id_ex_regwrite),
        .id_ex_memread     (id_ex_memread),
        .id_ex_memwrite    (id_ex_memwrite),
        .id_ex_opcode      (id_ex_opcode),
        .id_ex_funct       (id_ex_funct),
        .id_ex_nextpc      (id_ex_nextpc),
        .id_epc            (id_epc)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [31:0] instr, input logic [31:0] npc);
        if_id_instruc = instr;
        if_id_nextpc  = npc;
        #1;
    endtask

    task automatic wr(input logic [4:0] idx, input logic [31:0] data);
        wb_id_regwrite  = 1'b1;
        wb_id_writereg  = idx;
        wb_id_writedata = data;
        tick();
        wb_id_regwrite  = 1'b0;
    endtask

    // {regwrite, memread, memwrite, regdest, opcode, funct}
    function automatic logic [31:0] ctl();
        return {12'h000, id_ex_regwrite, id_ex_memread, id_ex_memwrite, id_ex_regdest,
                id_ex_opcode, id_ex_funct};
    endfunction

    logic [31:0] byp_exp;

    initial begin
        reset = 1'b0;
        if_id_instruc = 32'h0000_0000;
        if_id_nextpc = 32'h0000_0000;
        wb_id_regwrite = 1'b0;
        wb_id_writereg = 5'd0;
        wb_id_writedata = 32'h0000_0000;
        #3;
        chk("rst_ctl", ctl(), 32'h0000_0000);
        chk("rst_rega", id_ex_rega, 32'h0000_0000);
        chk("rst_nextpc", id_ex_nextpc, 32'h0000_0000);
        chk("rst_epc", id_epc, 32'h0000_0000);
        chk("rst_redirect", {31'd0, id_if_selpcsource}, 32'd0);
        tick();
        tick();
        reset = 1'b1;

        wr(5'd1, 32'd7);
        wr(5'd2, 32'd7);
        wr(5'd4, 32'h55);
        wr(5'd5, 32'h1234);
        wr(5'd9, 32'h1111);

        // BEQ r1,r2,-3
        drive(32'h1022_FFFD, 32'h10);
        chk("beq_taken", {29'd0, id_if_selpcsource, id_if_selpctype}, 32'h4);
        chk("beq_target", id_if_pcimd2ext, 32'h0000_000D);
        if_id_instruc = 32'h0000_0000;
        wr(5'd2, 32'd8);
        drive(32'h1022_FFFD, 32'h10);
        chk("beq_nottaken", {31'd0, id_if_selpcsource}, 32'd0);
        drive(32'h1422_FFFD, 32'h10);
        chk("bne_taken", {29'd0, id_if_selpcsource, id_if_selpctype}, 32'h4);

        // J / JAL / JR
        drive(32'h0800_0123, 32'hFC00_0005);
        chk("j_type", {29'd0, id_if_selpcsource, id_if_selpctype}, 32'h6);
        chk("j_index", id_if_pcindex, 32'hFC00_0123);
        drive(32'h0C00_0123, 32'h40);
        chk("jal_type", {29'd0, id_if_selpcsource, id_if_selpctype}, 32'h6);
        tick();
        chk("jal_ctl", ctl(), {12'h000, 1'b1, 1'b0, 1'b0, 5'd31, 6'h03, 6'h23});
        chk("jal_nextpc", id_ex_nextpc, 32'h40);
        drive(32'h0080_0008, 32'h41);
        chk("jr_type", {29'd0, id_if_selpcsource, id_if_selpctype}, 32'h5);
        chk("jr_rega", id_if_rega, 32'h55);
        tick();
        chk("jr_regwrite", {31'd0, id_ex_regwrite}, 32'd0);

        // illegal opcode, then squashed ADDI r3,r1,5 in the delay slot
        drive(32'hFC00_0000, 32'h21);
        chk("ill_type", {29'd0, id_if_selpcsource, id_if_selpctype}, 32'h7);
        tick();
        chk("ill_epc", id_epc, 32'h20);
        chk("ill_ctl", ctl(), 32'h0000_0000);
        drive(32'h2023_0005, 32'h22);
        chk("sq_redirect", {31'd0, id_if_selpcsource}, 32'd0);
        tick();
        chk("sq_ctl", ctl(), 32'h0000_0000);
        chk("sq_rega", id_ex_rega, 32'h0000_0000);
        chk("sq_epc_hold", id_epc, 32'h20);
        tick();
        chk("addi_ctl", ctl(), {12'h000, 1'b1, 1'b0, 1'b0, 5'd3, 6'h08, 6'h05});
        chk("addi_rega", id_ex_rega, 32'd7);
        chk("addi_imm", id_ex_imedext, 32'd5);

        // immediate forms and memory controls
        drive(32'h3423_FFFF, 32'h23);
        tick();
        chk("ori_zext", id_ex_imedext, 32'h0000_FFFF);
        drive(32'h3C03_1234, 32'h24);
        tick();
        chk("lui_imm", id_ex_imedext, 32'h1234_0000);
        drive(32'h2023_FFFF, 32'h25);
        tick();
        chk("addi_sext", id_ex_imedext, 32'hFFFF_FFFF);
        drive(32'h8C23_0004, 32'h26);
        tick();
        chk("lw_ctl", ctl(), {12'h000, 1'b1, 1'b1, 1'b0, 5'd3, 6'h23, 6'h04});
        drive(32'hAC22_0004, 32'h27);
        tick();
        chk("sw_ctl", ctl(), {12'h000, 1'b0, 1'b0, 1'b1, 5'd2, 6'h2B, 6'h04});
        chk("sw_regb", id_ex_regb, 32'd8);

        // same-cycle write/read of r9 via ADD r10,r9,r9
`ifdef DECODE_WB_BYPASS_EN
        byp_exp = 32'h0000_DEAD;
`else
        byp_exp = 32'h0000_1111;
`endif
        wb_id_regwrite  = 1'b1;
        wb_id_writereg  = 5'd9;
        wb_id_writedata = 32'h0000_DEAD;
        drive(32'h0129_5020, 32'h28);
        chk("byp_if_rega", id_if_rega, byp_exp);
        tick();
        wb_id_regwrite = 1'b0;
        chk("byp_ex_rega", id_ex_rega, byp_exp);
        chk("byp_ex_regb", id_ex_regb, byp_exp);
        #1;
        chk("r9_after", id_if_rega, 32'h0000_DEAD);

        // r0 stays zero
        if_id_instruc = 32'h0000_0000;
        wr(5'd0, 32'd5);
        drive(32'h0000_0008, 32'h29);
        chk("r0_read", id_if_rega, 32'h0000_0000);

        // asynchronous reset mid-run
        drive(32'h20A6_0000, 32'h50);
        chk("r5_before", id_if_rega, 32'h1234);
        tick();
        chk("r5_ex", id_ex_rega, 32'h1234);
        #2;
        if_id_instruc = 32'h0000_0000;
        reset = 1'b0;
        #1;
        chk("mrst_ctl", ctl(), 32'h0000_0000);
        chk("mrst_rega", id_ex_rega, 32'h0000_0000);
        chk("mrst_nextpc", id_ex_nextpc, 32'h0000_0000);
        chk("mrst_epc", id_epc, 32'h0000_0000);
        chk("mrst_redirect", {31'd0, id_if_selpcsource}, 32'd0);
        tick();
        reset = 1'b1;
        drive(32'h20A6_0000, 32'h51);
        chk("r5_cleared", id_if_rega, 32'h0000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/decode.md
Name: decode

Overview:
- ID stage of the 5-stage word-addressed MIPS-subset pipeline; the other end of the IF/ID interface.
- Consumes the fetched instruction and its next-PC from fetch.
- Drives the PC-redirect controls back to fetch.
- Owns the 32x32 register file, registers ID/EX control and operands, and raises the illegal-instruction exception.

Parameters:
- LINK_REG, 31, register written by JAL.
- EXC_VECTOR, 32'h0000_0040, exception target; must equal fetch's hardwired selpctype=11 target.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
if_id_instruc  in  32  instruction from fetch
if_id_nextpc  in  32  address of instruction + 1 (word-addressed)
id_if_selpcsource  out  1  redirect request (combinational)
id_if_selpctype  out  2  00 branch, 01 register (JR), 10 jump index, 11 exception
id_if_pcimd2ext  out  32  if_id_nextpc + sext(imm16), mod 2^32
id_if_rega  out  32  reg[rs] (JR target)
id_if_pcindex  out  32  {if_id_nextpc[31:26], instr[25:0]}
wb_id_regwrite  in  1  writeback enable
wb_id_writereg  in  5  writeback register
wb_id_writedata  in  32  writeback data
id_ex_rega, id_ex_regb  out  32  registered operands (rs, rt)
id_ex_imedext  out  32  registered extended immediate
id_ex_regdest  out  5  registered destination register
id_ex_regwrite, id_ex_memread, id_ex_memwrite  out  1  registered controls
id_ex_opcode, id_ex_funct  out  6  registered instruction fields
id_ex_nextpc  out  32  registered if_id_nextpc (JAL link value)
id_epc  out  32  exception PC

Behaviour:
- Fields: op[31:26], rs[25:21], rt[20:16], rd[15:11], funct[5:0], imm[15:0], index[25:0].
- Legal opcodes:
  - R-type op 0x00 with funct ADD 0x20, SUB 0x22, AND 0x24, OR 0x25, SLT 0x2A, SLL 0x00, JR 0x08.
  - ADDI 0x08, ANDI 0x0C, ORI 0x0D, LUI 0x0F, LW 0x23, SW 0x2B, BEQ 0x04, BNE 0x05, J 0x02, JAL 0x03.
  - Anything else is illegal.
- Immediate: ANDI/ORI zero-extend; LUI gives {imm,16'h0}; all others sign-extend.
- regdest: rd for R-type, LINK_REG for JAL, rt otherwise.
- regwrite=1: R-type except JR, ADDI/ANDI/ORI/LUI/LW, JAL.
- memread=1 only for LW; memwrite=1 only for SW.
- Redirect is combinational, same cycle as the instruction sits in ID:
  - BEQ taken when reg[rs]==reg[rt]; BNE taken when they differ; selpctype=00.
  - JR: selpctype=01. J/JAL: selpctype=10. Illegal: selpctype=11.
- One architectural delay slot: the instruction fetch latches during a branch/jump redirect executes normally.
- Exception:
  - Asserting redirect with type 11 loads id_epc <= if_id_nextpc - 1 and sets the squash flag.
  - Next cycle, the instruction in ID (the delay slot) is treated as NOP: no redirect, no exception, all id_ex controls 0. The flag then clears.
  - An exception inside a branch delay slot gives id_epc = target-1; this is accepted as imprecise.
- Register file:
  - r0 reads 0; writes to r0 are ignored.
  - Write occurs at the clock edge when wb_id_regwrite=1.
- No hazard detection or forwarding from EX/MEM; the compiler schedules around hazards.
- Illegal or squashed instruction: ID/EX registers load NOP (all controls 0, operands 0).
- ID/EX registers update every cycle; there is no stall.
- Reset (async, mid-operation too):
  - All id_ex_* = 0, id_epc = 0, squash = 0, every register = 0.
  - Combinational id_if_* then follow if_id_instruc=0 (SLL NOP) and must give selpcsource=0.

Optional Feature:
- DECODE_WB_BYPASS_EN defined: a read of a register being written the same cycle (wb_id_regwrite, matching nonzero index) returns wb_id_writedata, for both id_if_rega/branch compare and id_ex operands.
- Undefined: the read returns the stored (old) value.

Decomposition:
- Shared package holds the opcode/funct localparams, the selpctype codes (PCSRC_BRANCH/REG/INDEX/EXC), and the NOP encoding.
- One natural sub-module: regfile (2 async read ports, 1 sync write port, r0 hardwired, bypass under the macro).

Test Plan:
- Reset asserted mid-run with r5 written -> all id_ex_*=0, id_epc=0, r5 reads 0 after release, selpcsource=0.
- BEQ r1,r2,imm=-3 with r1=r2=7, nextpc=0x10 -> selpcsource=1, selpctype=00, pcimd2ext=0x0D; r2=8 -> selpcsource=0.
- J index=0x0000123 with nextpc=0xFC000005 -> selpctype=10, pcindex=0xFC000123.
- JAL -> id_ex_regdest=31, id_ex_regwrite=1, id_ex_nextpc=if_id_nextpc. JR r4 with r4=0x55 -> selpctype=01, rega=0x55.
- Illegal opcode 0x3F at nextpc=0x21 -> selpctype=11, id_epc=0x20. Next instruction ADDI r3 -> squashed: id_ex_regwrite=0, no redirect.
- Write r9=0xDEAD while reading r9 in the same cycle -> 0xDEAD with DECODE_WB_BYPASS_EN, old value without. Write r0=5 -> r0 reads 0.
